if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  ID stage cannot accept; hold the current output.
REQ-005 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and forced to 0.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  word-aligned fetch address.
REQ-009 imem_ack  input  1  memory response valid; may assert in the same cycle as imem_req.
REQ-010 imem_rdata  input  32  instruction word; sampled only when imem_ack=1.
REQ-011 inst  output  32  instruction to ID (feeds the immediate extender and decoder).
REQ-012 inst_pc  output  32  PC of inst.
REQ-013 inst_valid  output  1  inst/inst_pc are valid.

Function
REQ-014 States: FETCH (request out), HOLD (skid full, no request), FLUSH (discarding a stale response).
REQ-015 imem_req is 1 in FETCH and FLUSH and 0 in HOLD; it is forced to 0 while rst=1.
REQ-016 Once imem_req=1, imem_addr stays stable until the cycle imem_ack=1.
REQ-017 FETCH with ack, no redirect, and the output free (inst_valid=0 or stall=0): load inst=imem_rdata, inst_pc=pc, inst_valid=1, pc+=4, stay in FETCH. Latency is 1 cycle from ack to inst_valid.
REQ-018 FETCH with ack, no redirect, and the output full with stall=1: capture the data and PC into the skid register, pc+=4, go to HOLD.
REQ-019 HOLD with stall=0: move the skid contents to the output (inst_valid=1), go to FETCH.
REQ-020 When stall=1 and inst_valid=1, inst, inst_pc and inst_valid are held unchanged.
REQ-021 When stall=0 and no new data is loaded, inst_valid goes to 0 next edge.
REQ-022 redirect has priority over ack and stall; it sets pc=redirect_pc, clears inst_valid, and invalidates the skid register.
REQ-023 redirect in FETCH without ack (request outstanding): go to FLUSH, keeping the old address on imem_addr; on the next ack, discard the data and go to FETCH at the new pc.
REQ-024 redirect in the same cycle as ack: discard the data and stay in FETCH at the new pc with no FLUSH.
REQ-025 redirect in HOLD or FLUSH: FLUSH waits for its ack; HOLD goes to FETCH directly.
REQ-026 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.

Reset
REQ-027 Asynchronously on rst: pc=RESET_PC, state=FETCH, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0, skid invalid.
REQ-028 First request: imem_addr=RESET_PC in the first cycle after rst deasserts.
REQ-029 rst asserted mid-request abandons the transaction; any later ack belonging to it is not expected.

Configuration
REQ-030 IF_FETCH_PERF_CNT_EN defined: add output fetch_cnt (32 bits, reset 0), +1 per instruction loaded into the output register, wrapping at 2^32.
REQ-031 IF_FETCH_PERF_CNT_EN undefined: the fetch_cnt port and its counter are absent; all other behaviour is identical.

Structure
REQ-032 Shared package riscv_pkg holds NOP_INST, the default RESET_PC, and the IF state encodings.
REQ-033 One sub-module, if_pc, holds the PC register with its increment/redirect mux.
REQ-034 The FSM, skid register and output register live in if_fetch.

Verification
REQ-035 Reset, then ack on every cycle: addresses 0,4,8 in successive cycles; inst_valid=1 from the 2nd cycle; inst_pc follows 0,4,8.
REQ-036 stall=1 for 3 cycles while valid and ack arrives: output holds PC 4; skid takes PC 8; imem_req=0 in HOLD; after stall falls, PC 8 appears next cycle.
REQ-037 redirect to 0x100 with a request outstanding (ack delayed 2 cycles): imem_addr holds the old address; stale data is never valid; next request is 0x100.
REQ-038 redirect to 0x203 together with ack: data is dropped; next imem_addr=0x200; inst_valid=0 for that cycle.
REQ-039 redirect to 0xFFFF_FFFC: fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-040 With IF_FETCH_PERF_CNT_EN: 5 delivered and 1 flushed instruction give fetch_cnt=5; rst mid-run returns it to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and IF stage state encodings
package riscv_pkg;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {IF_S_FETCH, IF_S_HOLD, IF_S_FLUSH} if_state_t;
endpackage

// File: rtl/if_pc.sv
// if_pc: fetch PC register with sequential increment and redirect mux
module if_pc import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);
  // redirect wins over sequential advance; target forced to word alignment
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else pc <= redirect ? (redirect_pc & 32'hFFFF_FFFC) : inc ? pc + 32'd4 : pc;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with skid buffer and redirect flush; IF_FETCH_PERF_CNT_EN adds fetch_cnt
module if_fetch import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
`endif
  output logic        inst_valid
);
  if_state_t   state;
  logic [31:0] pc, flush_addr, skid_inst, skid_pc;
  logic        take, out_free, load_out;
  // accepted response, output availability, and memory request decode
  always_comb begin
    take      = state == IF_S_FETCH && imem_ack && !redirect;
    out_free  = !inst_valid || !stall;
    load_out  = (take && out_free) || (state == IF_S_HOLD && !stall && !redirect);
    imem_req  = !rst && state != IF_S_HOLD;
    imem_addr = state == IF_S_FLUSH ? flush_addr : pc;
  end
  if_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .inc(take),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .pc(pc)
  );
  // FSM, skid register and output register; HOLD state means the skid is full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IF_S_FETCH;
      inst_valid <= 1'b0;
      inst       <= NOP_INST;
      inst_pc    <= '0;
      skid_inst  <= NOP_INST;
      skid_pc    <= '0;
      flush_addr <= '0;
    end else if (redirect) begin
      inst_valid <= 1'b0;
      state      <= state != IF_S_HOLD && !imem_ack ? IF_S_FLUSH : IF_S_FETCH;
      if (state == IF_S_FETCH && !imem_ack) flush_addr <= pc;
    end else begin
      if (load_out) begin
        inst    <= state == IF_S_HOLD ? skid_inst : imem_rdata;
        inst_pc <= state == IF_S_HOLD ? skid_pc : pc;
      end
      inst_valid <= load_out || (inst_valid && stall);
      if (take && !out_free) begin
        skid_inst <= imem_rdata;
        skid_pc   <= pc;
      end
      state <= state == IF_S_HOLD  ? (stall ? IF_S_HOLD : IF_S_FETCH) :
               state == IF_S_FLUSH ? (imem_ack ? IF_S_FETCH : IF_S_FLUSH) :
               (take && !out_free ? IF_S_HOLD : IF_S_FETCH);
    end
`ifdef IF_FETCH_PERF_CNT_EN
  // counts instructions loaded into the output register
  always_ff @(posedge clk or posedge rst)
    if (rst) fetch_cnt <= '0;
    else if (load_out) fetch_cnt <= fetch_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: self-checking bench for if_fetch against a queue-based reference model
module tb_if_fetch;
  import riscv_pkg::*;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif
  int checks = 0, failures = 0;
  typedef struct packed {logic [31:0] i; logic [31:0] p;} ent_t;
  ent_t skid_q[$];
  logic [31:0] m_pc, m_stale_addr, m_inst, m_ipc, m_cnt;
  logic m_stale, m_valid;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .inst(inst),
    .inst_pc(inst_pc),
`ifdef IF_FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt),
`endif
    .inst_valid(inst_valid)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic m_req();
    return skid_q.size() == 0;
  endfunction
  function automatic logic [31:0] m_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    skid_q.delete();
    m_pc = 32'h0; m_stale = 1'b0; m_stale_addr = '0;
    m_valid = 1'b0; m_inst = NOP_INST; m_ipc = '0; m_cnt = '0;
  endtask

  task automatic deliver(input ent_t e);
    m_inst = e.i; m_ipc = e.p; m_valid = 1'b1; m_cnt++;
  endtask

  task automatic model_edge(input logic s, input logic r, input logic [31:0] rp, input logic a);
    logic req;
    logic got;
    ent_t e;
    req = m_req();
    got = 1'b0;
    e = '0;
    if (r) begin
      if (req && !a) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1'b1;
      end else m_stale = 1'b0;
      skid_q.delete();
      m_valid = 1'b0;
      m_pc = rp & 32'hFFFF_FFFC;
    end else begin
      if (req && a && !m_stale) begin
        e.i = mem(m_pc); e.p = m_pc; m_pc = m_pc + 32'd4; got = 1'b1;
      end
      if (req && a) m_stale = 1'b0;
      if (got && m_valid && s) skid_q.push_back(e);
      else if (got) deliver(e);
      else if (skid_q.size() != 0 && !s) deliver(skid_q.pop_front());
      else if (!s) m_valid = 1'b0;
    end
  endtask

  task automatic compare();
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    if (m_req()) chk("imem_addr", imem_addr, m_addr());
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_cnt);
`endif
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic a);
    logic aa;
    aa = a && m_req();
    stall = s; redirect = r; redirect_pc = rp; imem_ack = aa;
    imem_rdata = aa ? mem(m_addr()) : $urandom;
    @(posedge clk);
    model_edge(s, r, rp, aa);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare();
    chk("first_addr", imem_addr, 32'h0);
  endtask

  initial begin
    do_reset();
    step(0, 0, 0, 1);
    chk("seq_addr1", imem_addr, 32'h4);
    chk("seq_pc0", inst_pc, 32'h0);
    chk("seq_valid", 32'(inst_valid), 32'h1);
    step(0, 0, 0, 1);
    chk("seq_addr2", imem_addr, 32'h8);
    chk("seq_pc1", inst_pc, 32'h4);
    step(1, 0, 0, 1);
    chk("hold_req", 32'(imem_req), 32'h0);
    chk("hold_pc", inst_pc, 32'h4);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("hold_pc2", inst_pc, 32'h4);
    step(0, 0, 0, 0);
    chk("skid_out_pc", inst_pc, 32'h8);
    chk("skid_out_valid", 32'(inst_valid), 32'h1);
    chk("after_hold_addr", imem_addr, 32'hC);
    step(0, 1, 32'h100, 0);
    chk("flush_addr_hold", imem_addr, 32'hC);
    chk("flush_valid", 32'(inst_valid), 32'h0);
    step(0, 0, 0, 0);
    chk("flush_addr_hold2", imem_addr, 32'hC);
    step(0, 0, 0, 1);
    chk("stale_dropped", 32'(inst_valid), 32'h0);
    chk("flush_next_addr", imem_addr, 32'h100);
    step(0, 0, 0, 1);
    chk("flush_new_pc", inst_pc, 32'h100);
    step(0, 1, 32'h203, 1);
    chk("redir_ack_addr", imem_addr, 32'h200);
    chk("redir_ack_valid", 32'(inst_valid), 32'h0);
    step(0, 0, 0, 1);
    chk("redir_ack_pc", inst_pc, 32'h200);
    step(0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_pc1", inst_pc, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
    do_reset();
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1);
    step(0, 1, 32'h40, 0);
    step(0, 0, 0, 1);
    chk("cnt_five", fetch_cnt, 32'd5);
    do_reset();
    chk("cnt_reset", fetch_cnt, 32'd0);
`endif
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rp;
      rp = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      if (n == 1500) do_reset();
      step($urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, rp, $urandom_range(0, 9) < 6);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
